// File: rtl/rf_window_gen_if.sv
// rtl/rf_window_gen_if.sv - pixel-in / window-out stream bundle for rf_window_gen
interface rf_window_gen_if #(
  parameter int WORDWIDTH = 32,
  parameter int ARRAYLEN  = 25
) ();
  logic [WORDWIDTH-1:0]          din;
  logic                          in_valid;
  logic                          in_ready;
  logic [ARRAYLEN*WORDWIDTH-1:0] dout;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, out_last
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, out_last
  );
endinterface

// File: rtl/rf_window_gen.sv
// rtl/rf_window_gen.sv - sliding K x K window generator over a raster pixel stream
// Line buffers keep the previous K-1 rows per column; the window register shifts one column per pixel.
module rf_window_gen #(
  parameter int WORDWIDTH  = 32,
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int KLEN       = 5,
  parameter int STRIDE     = 1
) (
  input logic             clk,
  input logic             rst,
  rf_window_gen_if.slave  bus
);
  localparam int ARRAYLEN = KLEN * KLEN;
  localparam int OUT_W    = (FIG_WIDTH - KLEN) / STRIDE + 1;
  localparam int OUT_H    = (FIG_HEIGHT - KLEN) / STRIDE + 1;
  localparam int NWIN     = OUT_W * OUT_H;
  localparam int CW       = $clog2(FIG_WIDTH);
  localparam int RW       = $clog2(FIG_HEIGHT);
  localparam int NW       = $clog2(NWIN + 1);

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [NW-1:0]        win_cnt;
  logic                 ov_q;
  logic                 last_q;
  logic                 accept;
  logic                 col_end;
  logic                 row_end;
  logic                 anchor;
  logic                 last_win;

  logic [WORDWIDTH-1:0] lb      [KLEN-1][FIG_WIDTH];
  logic [WORDWIDTH-1:0] win     [KLEN][KLEN];
  logic [WORDWIDTH-1:0] new_col [KLEN];

  assign bus.in_ready  = !ov_q || bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = last_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign col_end       = (col == CW'(FIG_WIDTH - 1));
  assign row_end       = (row == RW'(FIG_HEIGHT - 1));
  assign last_win      = (win_cnt == NW'(NWIN - 1));

  // A window completes only on stride-aligned anchors fully inside the current row band.
  always_comb begin
    anchor = (int'(row) >= KLEN - 1) && (int'(col) >= KLEN - 1) &&
             ((int'(row) - (KLEN - 1)) % STRIDE == 0) &&
             ((int'(col) - (KLEN - 1)) % STRIDE == 0);
  end

  always_comb begin
    for (int k = 0; k < KLEN - 1; k++) begin
      new_col[k] = lb[k][col];
    end
    new_col[KLEN-1] = bus.din;
  end

  always_comb begin
    bus.dout = '0;
    for (int kr = 0; kr < KLEN; kr++) begin
      for (int kc = 0; kc < KLEN; kc++) begin
        bus.dout[(kr*KLEN+kc)*WORDWIDTH +: WORDWIDTH] = win[kr][kc];
      end
    end
  end

  // Per-column vertical shift; stale contents age out before any anchor row reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < KLEN - 2; k++) begin
        lb[k][col] <= lb[k+1][col];
      end
      lb[KLEN-2][col] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      win_cnt <= '0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      for (int kr = 0; kr < KLEN; kr++) begin
        for (int kc = 0; kc < KLEN; kc++) begin
          win[kr][kc] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int kr = 0; kr < KLEN; kr++) begin
          for (int kc = 0; kc < KLEN - 1; kc++) begin
            win[kr][kc] <= win[kr][kc+1];
          end
          win[kr][KLEN-1] <= new_col[kr];
        end
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) begin
          row <= row_end ? '0 : row + RW'(1);
        end
        if (col_end && row_end) begin
          win_cnt <= '0;
        end else if (anchor) begin
          win_cnt <= win_cnt + NW'(1);
        end
      end
      if (accept && anchor) begin
        ov_q   <= 1'b1;
        last_q <= last_win;
      end else if (bus.out_ready) begin
        ov_q   <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rf_window_gen.sv
// tb/tb_rf_window_gen.sv - self-checking bench for rf_window_gen (W=H=6, K=3, strides 1 and 2)
module tb_rf_window_gen;
  localparam int WW = 32;
  localparam int AL = 9;
  localparam int DW = AL * WW;

  typedef struct {
    int          stride;
    int          frames;
    int          vprob;
    int          rprob;
    int          stall;
    bit          mid_rst;
    bit          frame_off;
    int          exp_n;
    int          probe;
    logic [71:0] pw;
    bit          probe_last;
  } scen_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [DW-1:0] obs_w[$];
  bit            obs_l[$];

  always #5 clk = ~clk;

  rf_window_gen_if #(.WORDWIDTH(WW), .ARRAYLEN(AL)) if0 ();
  rf_window_gen_if #(.WORDWIDTH(WW), .ARRAYLEN(AL)) if1 ();

  rf_window_gen #(.WORDWIDTH(WW), .FIG_WIDTH(6), .FIG_HEIGHT(6), .KLEN(3), .STRIDE(1))
    dut_s1 (.clk(clk), .rst(rst), .bus(if0));
  rf_window_gen #(.WORDWIDTH(WW), .FIG_WIDTH(6), .FIG_HEIGHT(6), .KLEN(3), .STRIDE(2))
    dut_s2 (.clk(clk), .rst(rst), .bus(if1));

  task automatic check_val(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7,
                                     input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [DW-1:0] unpack9(input logic [71:0] p);
    logic [DW-1:0] w;
    for (int i = 0; i < AL; i++) w[i*WW +: WW] = 32'(p[i*8 +: 8]);
    return w;
  endfunction

  function automatic logic [DW-1:0] mk_win(input int ar, input int ac, input int off);
    logic [DW-1:0] w;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        w[(kr*3+kc)*WW +: WW] = 32'((ar - 2 + kr) * 6 + (ac - 2 + kc) + off);
    return w;
  endfunction

  task automatic drive(input int sel, input bit v, input logic [WW-1:0] d, input bit r);
    if (sel == 0) begin
      if0.in_valid = v; if0.din = d; if0.out_ready = r;
    end else begin
      if1.in_valid = v; if1.din = d; if1.out_ready = r;
    end
  endtask

  task automatic sample(input int sel, output bit ir, output bit ov, output bit ol,
                        output logic [DW-1:0] dw);
    if (sel == 0) begin
      ir = if0.in_ready; ov = if0.out_valid; ol = if0.out_last; dw = if0.dout;
    end else begin
      ir = if1.in_ready; ov = if1.out_valid; ol = if1.out_last; dw = if1.dout;
    end
  endtask

  task automatic check_reset(input int sel);
    bit ir, ov, ol;
    logic [DW-1:0] dw;
    sample(sel, ir, ov, ol, dw);
    check_val($sformatf("rst_in_ready_%0d", sel), int'(ir), 1);
    check_val($sformatf("rst_out_valid_%0d", sel), int'(ov), 0);
    check_val($sformatf("rst_out_last_%0d", sel), int'(ol), 0);
    check_win($sformatf("rst_dout_%0d", sel), dw, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b1);
    drive(1, 1'b0, '0, 1'b1);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int sel, input int npix, input int vprob, input int rprob,
                     input int stall, input bit drain, input bit frame_off);
    int pidx = 0;
    int cyc = 0;
    int acc14 = -1;
    int first_ov = -1;
    int last_acc = -1;
    int stall_left = stall;
    bit v, r, ir, ov, ol;
    logic [DW-1:0] dw, held;
    logic [WW-1:0] d;
    held = '0;
    while (1) begin
      @(negedge clk);
      sample(sel, ir, ov, ol, dw);
      if (stall_left > 0 && ov) r = 1'b0;
      else if (pidx >= npix || rprob >= 100) r = 1'b1;
      else r = ($urandom_range(99) < rprob);
      v = (pidx < npix) && (vprob >= 100 || $urandom_range(99) < vprob);
      d = 32'((pidx % 36) + (frame_off ? 100 * (pidx / 36) : 0));
      drive(sel, v, d, r);
      #1;
      sample(sel, ir, ov, ol, dw);
      check_val("in_ready_rule", int'(ir), int'(!ov || r));
      if (stall_left > 0 && ov) begin
        check_val("stall_in_ready", int'(ir), 0);
        if (stall_left == stall) held = dw;
        else check_win("stall_dout", dw, held);
        stall_left--;
      end
      if (ov && r) begin
        obs_w.push_back(dw);
        obs_l.push_back(ol);
      end
      if (v && ir) begin
        if (pidx == 14 && acc14 < 0) acc14 = cyc;
        pidx++;
        last_acc = cyc;
      end
      if (ov && first_ov < 0) first_ov = cyc;
      cyc++;
      if (pidx == npix && (!drain || (cyc - 1 > last_acc && !ov))) break;
      if (cyc > 3000) begin
        check_val("run_timeout", 0, 1);
        break;
      end
    end
    if (drain) check_val("first_latency", first_ov, acc14 + 1);
    drive(sel, 1'b0, '0, 1'b1);
  endtask

  initial begin
    scen_t tbl[7];
    tbl[0] = '{stride:1, frames:1, vprob:100, rprob:100, stall:0, mid_rst:0, frame_off:0, exp_n:16,
               probe:15, pw:w9(21,22,23,27,28,29,33,34,35), probe_last:1};
    tbl[1] = '{stride:2, frames:1, vprob:100, rprob:100, stall:0, mid_rst:0, frame_off:0, exp_n:4,
               probe:1, pw:w9(2,3,4,8,9,10,14,15,16), probe_last:0};
    tbl[2] = '{stride:1, frames:1, vprob:100, rprob:100, stall:3, mid_rst:0, frame_off:0, exp_n:16,
               probe:0, pw:w9(0,1,2,6,7,8,12,13,14), probe_last:0};
    tbl[3] = '{stride:1, frames:1, vprob:100, rprob:100, stall:0, mid_rst:1, frame_off:0, exp_n:16,
               probe:0, pw:w9(0,1,2,6,7,8,12,13,14), probe_last:0};
    tbl[4] = '{stride:1, frames:2, vprob:100, rprob:100, stall:0, mid_rst:0, frame_off:1, exp_n:32,
               probe:16, pw:w9(100,101,102,106,107,108,112,113,114), probe_last:0};
    tbl[5] = '{stride:1, frames:2, vprob:50, rprob:50, stall:0, mid_rst:0, frame_off:1, exp_n:32,
               probe:31, pw:w9(121,122,123,127,128,129,133,134,135), probe_last:1};
    tbl[6] = '{stride:2, frames:2, vprob:50, rprob:50, stall:0, mid_rst:0, frame_off:1, exp_n:8,
               probe:7, pw:w9(114,115,116,120,121,122,126,127,128), probe_last:1};

    drive(0, 1'b0, '0, 1'b1);
    drive(1, 1'b0, '0, 1'b1);
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      int sel;
      int n;
      sel = (tbl[i].stride == 1) ? 0 : 1;
      obs_w.delete();
      obs_l.delete();
      if (tbl[i].mid_rst) begin
        run(sel, 20, 100, 100, 0, 1'b0, 1'b0);
        apply_reset();
        obs_w.delete();
        obs_l.delete();
      end
      run(sel, 36 * tbl[i].frames, tbl[i].vprob, tbl[i].rprob, tbl[i].stall, 1'b1, tbl[i].frame_off);
      check_val($sformatf("s%0d_window_count", i), obs_w.size(), tbl[i].exp_n);
      n = 0;
      for (int f = 0; f < tbl[i].frames; f++) begin
        for (int ar = 2; ar < 6; ar += tbl[i].stride) begin
          for (int ac = 2; ac < 6; ac += tbl[i].stride) begin
            if (n < obs_w.size()) begin
              check_win($sformatf("s%0d_win%0d", i, n), obs_w[n],
                        mk_win(ar, ac, tbl[i].frame_off ? 100 * f : 0));
              check_val($sformatf("s%0d_last%0d", i, n), int'(obs_l[n]),
                        int'((ar + tbl[i].stride >= 6) && (ac + tbl[i].stride >= 6)));
            end
            n++;
          end
        end
      end
      if (tbl[i].probe < obs_w.size()) begin
        check_win($sformatf("s%0d_probe", i), obs_w[tbl[i].probe], unpack9(tbl[i].pw));
        check_val($sformatf("s%0d_probe_last", i), int'(obs_l[tbl[i].probe]), int'(tbl[i].probe_last));
      end else begin
        check_val($sformatf("s%0d_probe_present", i), 0, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rf_window_gen.md
RF_WINDOW_GEN -- requirements
Module: rf_window_gen

Interface
REQ-001 SHALL have parameter WORDWIDTH, default 32: bits per pixel word.
REQ-002 SHALL have parameter FIG_WIDTH, default 28: image columns (W).
REQ-003 SHALL have parameter FIG_HEIGHT, default 28: image rows (H).
REQ-004 SHALL have parameter KLEN, default 5: kernel side (K); legal range 2 <= K <= min(W,H).
REQ-005 SHALL have parameter STRIDE, default 1: window step (S) in both axes; S >= 1.
REQ-006 SHALL have derived localparam ARRAYLEN = K*K, OUT_W = (W-K)/S+1, OUT_H = (H-K)/S+1.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port din, input, WORDWIDTH: pixel, raster order (row-major, top-left first).
REQ-010 SHALL have port in_valid, input, 1: din valid.
REQ-011 SHALL have port in_ready, output, 1: block accepts din this cycle.
REQ-012 SHALL have port dout, output, ARRAYLEN*WORDWIDTH: flattened K x K window.
REQ-013 SHALL have port out_valid, output, 1: dout valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts dout.
REQ-015 SHALL have port out_last, output, 1: qualifies the final window of a frame.

Function
REQ-016 SHALL accept a pixel only on in_valid && in_ready, i.e. on a handshake; pixels without a handshake SHALL be ignored.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational, no skid buffer).
REQ-018 SHALL track the accepted pixel position with column counter c (0..W-1) and row counter r (0..H-1); c wraps to 0 and r increments after c = W-1; r wraps to 0 after the pixel at (H-1, W-1), starting the next frame with no idle cycle.
REQ-019 SHALL hold the previous K-1 rows in line buffers of W words each; implementation is free to use shift registers or RAM.
REQ-020 SHALL treat the pixel at (r,c) as completing a window when r >= K-1, c >= K-1, (r-K+1) mod S = 0 and (c-K+1) mod S = 0.
REQ-021 SHALL assert out_valid on the cycle after the completing pixel's handshake, i.e. latency 1 clock.
REQ-022 SHALL place window element (kr,kc) in dout[(kr*K+kc)*WORDWIDTH +: WORDWIDTH], where kr=0 is the top row and kc=0 the leftmost column of the window.
REQ-023 SHALL hold dout, out_valid and out_last stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after the out_valid && out_ready handshake, unless a new window completes on that same cycle, in which case out_valid stays 1 and dout updates.
REQ-025 SHALL count emitted windows per frame and assert out_last with the (OUT_H*OUT_W)-th window; the count SHALL reset to 0 at the frame wrap.
REQ-026 SHALL emit no window spanning a row boundary, i.e. no window mixing the end of one row with the start of the next.
REQ-027 SHALL emit no window mixing pixels of two frames.
REQ-028 SHALL ignore pixels beyond the last anchor row or column (stride remainder) for output purposes but still count them.

Reset
REQ-029 SHALL on rst clear r, c and the window count, and force out_valid=0, out_last=0 and dout=0; in_ready SHALL then be 1.
REQ-030 SHALL not require line-buffer contents to be cleared.
REQ-031 SHALL, after a mid-frame rst, treat the next accepted pixel as (0,0) of a fresh frame, with output bit-identical to a frame started after power-on reset.

Verification (W=H=6, K=3, pixel value = r*6+c unless noted)
REQ-032 SHALL cover: S=1, in_valid held high and out_ready held high -> first out_valid the cycle after pixel 14, dout words {0,1,2,6,7,8,12,13,14}; 16 windows in total; out_last only on the 16th, whose words are {21,22,23,27,28,29,33,34,35}.
REQ-033 SHALL cover: S=2 -> 4 windows, the 2nd being {2,3,4,8,9,10,14,15,16}; no out_valid for anchors with odd offset; out_last on the 4th.
REQ-034 SHALL cover: S=1, out_ready=0 for 3 cycles while out_valid=1 -> dout stable; in_ready=0 for those 3 cycles; all 36 pixels accepted in the end; window sequence identical to the first scenario.
REQ-035 SHALL cover: rst asserted after 20 pixels, then a full frame -> output identical to the first scenario; no stale window appears.
REQ-036 SHALL cover: two back-to-back frames, second frame values +100 -> 32 windows in total; out_last on the 16th and 32nd; the first window of frame 2 is {100,101,102,106,107,108,112,113,114}.
REQ-037 SHALL cover: random in_valid/out_ready (50%) against a reference model -> no lost, duplicated or reordered windows.
